// File: rtl/parking_slot_ctrl.sv
// Car-park slot controller: per-slot occupancy/timestamps, check-in auto-assign, check-out duration.
// Latency: request rising edge detected at edge N, done/err pulse after edge N+1.
// Backpressure: busy for one cycle after detection; request edges seen while busy are dropped.
module parking_slot_ctrl #(
    parameter int NSLOT = 6,
    parameter int TW    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             checkin_req,
    input  logic             checkout_req,
    input  logic [3:0]       selector,
    input  logic [TW-1:0]    timer,
    output logic [NSLOT-1:0] occupied,
    output logic [2:0]       free_count,
    output logic             full,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [2:0]       slot_out,
    output logic [TW-1:0]    duration
);

    typedef enum logic {IDLE, EXEC} state_t;
    typedef enum logic [1:0] {OP_IN, OP_OUT, OP_BOTH} op_t;

    state_t           state_q, state_d;
    op_t              op_q, ev_op;
    logic             in_q, out_q;
    logic             in_ev, out_ev, accept;
    logic [3:0]       sel_q;
    logic [TW-1:0]    snap_q;
    logic [TW-1:0]    ts_q [NSLOT];

    logic             free_found, sel_ok, ok;
    logic [2:0]       free_slot, tgt, free_n;
    logic [1:0]       code;
    logic [NSLOT-1:0] tgt_mask, occ_n;
    logic [TW-1:0]    ts_sel, dur_n;

    // History resets to 1 so a level already high at reset release is not an edge.
    assign in_ev  = checkin_req  & ~in_q;
    assign out_ev = checkout_req & ~out_q;
    assign accept = (state_q == IDLE) && (in_ev || out_ev);
    assign busy   = (state_q == EXEC);

    always_comb begin
        state_d = state_q;
        ev_op   = OP_IN;
        if (in_ev && out_ev)
            ev_op = OP_BOTH;
        else if (out_ev)
            ev_op = OP_OUT;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        free_found = 1'b0;
        free_slot  = 3'd0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!occupied[i]) begin
                free_found = 1'b1;
                free_slot  = 3'(i + 1);
            end
        end
        sel_ok   = (sel_q != 4'd0) && (sel_q <= 4'(NSLOT));
        tgt      = (op_q == OP_IN && sel_q == 4'd0) ? free_slot : sel_q[2:0];
        // tgt of 0 shifts the bit out, giving an empty mask.
        tgt_mask = NSLOT'(1) << (tgt - 3'd1);
        ts_sel   = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (tgt_mask[i]) ts_sel = ts_q[i];
        end
        dur_n = snap_q - ts_sel;

        ok    = 1'b0;
        code  = 2'd0;
        occ_n = occupied;
        case (op_q)
            OP_IN: begin
                if (sel_q == 4'd0)
                    code = free_found ? 2'd0 : 2'd2;
                else if (!sel_ok)
                    code = 2'd1;
                else if (|(occupied & tgt_mask))
                    code = 2'd2;
                ok = (code == 2'd0);
                if (ok) occ_n = occupied | tgt_mask;
            end
            OP_OUT: begin
                if (!sel_ok)
                    code = 2'd1;
                else if (!(|(occupied & tgt_mask)))
                    code = 2'd3;
                ok = (code == 2'd0);
                if (ok) occ_n = occupied & ~tgt_mask;
            end
            default: code = 2'd1;
        endcase

        free_n = 3'd0;
        for (int i = 0; i < NSLOT; i++) begin
            if (!occ_n[i]) free_n = free_n + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_q       <= 1'b1;
            out_q      <= 1'b1;
            op_q       <= OP_IN;
            sel_q      <= 4'd0;
            snap_q     <= '0;
            occupied   <= '0;
            free_count <= 3'(NSLOT);
            full       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            slot_out   <= 3'd0;
            duration   <= '0;
            for (int i = 0; i < NSLOT; i++) ts_q[i] <= '0;
        end else begin
            state_q <= state_d;
            in_q    <= checkin_req;
            out_q   <= checkout_req;
            done    <= 1'b0;
            err     <= 1'b0;
            if (accept) begin
                op_q   <= ev_op;
                sel_q  <= selector;
                snap_q <= timer;
            end
            if (state_q == EXEC) begin
                if (ok) begin
                    occupied   <= occ_n;
                    free_count <= free_n;
                    full       <= (free_n == 3'd0);
                    slot_out   <= tgt;
                    done       <= 1'b1;
                    if (op_q == OP_IN) begin
                        for (int i = 0; i < NSLOT; i++)
                            if (tgt_mask[i]) ts_q[i] <= snap_q;
                    end else begin
                        duration <= dur_n;
                    end
                end else begin
                    err      <= 1'b1;
                    err_code <= code;
                end
            end
        end
    end

endmodule

// File: tb/tb_parking_slot_ctrl.sv
// Directed bench for parking_slot_ctrl: hand-computed occupancy, duration and error codes.
module tb_parking_slot_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        checkin_req, checkout_req;
    logic [3:0]  selector;
    logic [10:0] timer;
    logic [5:0]  occupied;
    logic [2:0]  free_count;
    logic        full, busy, done, err;
    logic [1:0]  err_code;
    logic [2:0]  slot_out;
    logic [10:0] duration;

    int n_tests = 0;
    int n_fail  = 0;

    parking_slot_ctrl #(.NSLOT(6), .TW(11)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .checkin_req  (checkin_req),
        .checkout_req (checkout_req),
        .selector     (selector),
        .timer        (timer),
        .occupied     (occupied),
        .free_count   (free_count),
        .full         (full),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .slot_out     (slot_out),
        .duration     (duration)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Raise request(s) on a negedge, drop them one cycle later, check the result pulse.
    task automatic run_op(input string tag, input logic ci, input logic co,
                          input logic [3:0] sel, input logic [10:0] t,
                          input logic exp_done, input logic [1:0] exp_code);
        @(negedge clk);
        checkin_req  = ci;
        checkout_req = co;
        selector     = sel;
        timer        = t;
        @(negedge clk);
        check({tag, ".busy"}, busy, 1);
        check({tag, ".early"}, {done, err}, 0);
        checkin_req  = 1'b0;
        checkout_req = 1'b0;
        @(negedge clk);
        check({tag, ".done"}, done, exp_done);
        check({tag, ".err"}, err, !exp_done);
        check({tag, ".idle"}, busy, 0);
        if (!exp_done) check({tag, ".code"}, err_code, exp_code);
    endtask

    initial begin
        rst_n        = 1'b0;
        checkin_req  = 1'b0;
        checkout_req = 1'b0;
        selector     = 4'd0;
        timer        = 11'd0;
        repeat (2) @(negedge clk);
        check("rst.occ", occupied, 0);
        check("rst.free", free_count, 6);
        check("rst.full", full, 0);
        check("rst.busy", busy, 0);
        check("rst.pulse", {done, err}, 0);
        check("rst.code", err_code, 0);
        check("rst.slot", slot_out, 0);
        check("rst.dur", duration, 0);
        rst_n = 1'b1;

        // Auto-assign three slots at t=100.
        for (int k = 1; k <= 3; k++) begin
            run_op("ci_auto", 1, 0, 4'd0, 11'd100, 1, 0);
            check("ci_auto.slot", slot_out, k);
        end
        check("ci3.occ", occupied, 6'b000111);
        check("ci3.free", free_count, 3);

        run_op("co2", 0, 1, 4'd2, 11'd350, 1, 0);
        check("co2.dur", duration, 250);
        check("co2.slot", slot_out, 2);
        check("co2.occ", occupied, 6'b000101);
        check("co2.free", free_count, 4);

        // Timer wrap: 2040 -> 10 is 18 ticks.
        run_op("ci4", 1, 0, 4'd4, 11'd2040, 1, 0);
        check("ci4.occ", occupied, 6'b001101);
        run_op("co4", 0, 1, 4'd4, 11'd10, 1, 0);
        check("co4.dur", duration, 18);
        check("co4.occ", occupied, 6'b000101);

        // Fill: lowest free are 2,4,5,6.
        run_op("fill2", 1, 0, 4'd0, 11'd500, 1, 0);
        check("fill2.slot", slot_out, 2);
        run_op("fill4", 1, 0, 4'd0, 11'd500, 1, 0);
        check("fill4.slot", slot_out, 4);
        run_op("fill5", 1, 0, 4'd0, 11'd500, 1, 0);
        run_op("fill6", 1, 0, 4'd0, 11'd500, 1, 0);
        check("fill6.slot", slot_out, 6);
        check("full.occ", occupied, 6'b111111);
        check("full.full", full, 1);
        check("full.free", free_count, 0);

        run_op("ci_full", 1, 0, 4'd0, 11'd550, 0, 2);
        check("ci_full.occ", occupied, 6'b111111);
        check("ci_full.slot", slot_out, 6);
        check("ci_full.dur", duration, 18);
        run_op("ci_taken", 1, 0, 4'd3, 11'd550, 0, 2);

        run_op("co5", 0, 1, 4'd5, 11'd600, 1, 0);
        check("co5.dur", duration, 100);
        check("co5.occ", occupied, 6'b101111);
        check("co5.full", full, 0);
        check("co5.free", free_count, 1);
        run_op("co_empty", 0, 1, 4'd5, 11'd610, 0, 3);
        run_op("ci_sel9", 1, 0, 4'd9, 11'd620, 0, 1);
        run_op("co_sel0", 0, 1, 4'd0, 11'd620, 0, 1);
        run_op("co_sel7", 0, 1, 4'd7, 11'd620, 0, 1);
        run_op("both", 1, 1, 4'd5, 11'd630, 0, 1);
        check("both.occ", occupied, 6'b101111);
        check("both.dur", duration, 100);

        // Checkout edge during the busy cycle must be dropped.
        @(negedge clk);
        checkin_req = 1'b1;
        selector    = 4'd5;
        timer       = 11'd700;
        @(negedge clk);
        checkin_req  = 1'b0;
        checkout_req = 1'b1;
        @(negedge clk);
        check("busy_ev.done", done, 1);
        check("busy_ev.slot", slot_out, 5);
        check("busy_ev.code", err_code, 1);
        @(negedge clk);
        check("busy_ev.none", {done, err, busy}, 0);
        checkout_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("busy_ev.quiet", {done, err, busy}, 0);
        end
        check("busy_ev.occ", occupied, 6'b111111);
        check("busy_ev.dur", duration, 100);

        // Request held high through reset release.
        @(negedge clk);
        rst_n       = 1'b0;
        checkin_req = 1'b1;
        selector    = 4'd0;
        @(negedge clk);
        check("hold.rst_occ", occupied, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("hold.quiet", {done, err, busy}, 0);
        end
        check("hold.occ", occupied, 0);
        checkin_req = 1'b0;

        // Reset during EXEC discards the operation.
        @(negedge clk);
        @(negedge clk);
        checkin_req = 1'b1;
        timer       = 11'd50;
        @(negedge clk);
        check("rexec.busy", busy, 1);
        rst_n       = 1'b0;
        checkin_req = 1'b0;
        #1;
        check("rexec.busy_clr", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rexec.quiet", {done, err}, 0);
        end
        check("rexec.occ", occupied, 0);
        check("rexec.free", free_count, 6);
        check("rexec.slot", slot_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/parking_slot_ctrl.md
Name: parking_slot_ctrl

Overview:
- Controller for the car-park check-in/check-out datapath.
- Owns per-slot occupancy and check-in timestamps, and arbitrates check-in and check-out requests against the shared free-running timer.
- On check-in, auto-assigns the lowest free slot when no slot is selected.
- On check-out, returns parked duration to the fee/display logic.

Parameters:
- NSLOT, 6, number of parking slots; legal range 1..7, slots numbered 1..NSLOT.
- TW, 11, timer and timestamp width in bits.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- checkin_req  input  1  check-in request level; already debounced and synchronous to clk.
- checkout_req  input  1  check-out request level; already debounced and synchronous to clk.
- selector  input  4  requested slot: 0 = auto (check-in only), 1..NSLOT = explicit slot.
- timer  input  TW  free-running time count; wraps from 2^TW-1 to 0.
- occupied  output  NSLOT  bit i-1 set = slot i occupied.
- free_count  output  3  number of free slots.
- full  output  1  all slots occupied.
- busy  output  1  operation in progress; new requests are ignored.
- done  output  1  one-cycle pulse: operation completed successfully.
- err  output  1  one-cycle pulse: operation rejected.
- err_code  output  2  0 none, 1 bad selector/simultaneous, 2 slot taken/car park full, 3 slot empty; valid with err, holds until next err.
- slot_out  output  3  slot acted on by the last done.
- duration  output  TW  parked time from the last successful check-out.

Behaviour:
- Reset values (asynchronous, all state):
  - occupied=0, free_count=NSLOT, full=0, busy=0, done=0, err=0, err_code=0, slot_out=0, duration=0.
  - All timestamps=0; FSM in IDLE.
  - Request history registers reset to 1, so a request held high through reset release does not fire; it must be seen low first.
- Edge detect: an event fires at a clk edge where the request is sampled 1 and was 0 at the previous edge. Levels are otherwise ignored.
- FSM states: IDLE, EXEC.
- IDLE → EXEC on any event at edge N:
  - Latch op type, selector and timer snapshot.
  - busy=1 during cycle N..N+1.
- EXEC → IDLE at edge N+1:
  - Perform the update.
  - Pulse done or err for exactly one cycle after edge N+1; busy returns to 0.
  - Latency: request edge to done/err = 1 cycle after detection.
- Events while busy are discarded, not queued.
- Both events at the same edge: enter EXEC, no state change, err with code 1.
- Check-in:
  - selector 0: choose the lowest-numbered free slot. If full, err code 2.
  - selector 1..NSLOT: if the slot is free, use it; otherwise err code 2.
  - selector >NSLOT: err code 1.
  - On success: set the occupied bit, store the snapshot as that slot's timestamp, slot_out=slot, done.
- Check-out:
  - selector 0 or >NSLOT: err code 1.
  - Slot free: err code 3.
  - On success: duration=(snapshot − timestamp) mod 2^TW, clear the occupied bit, slot_out=slot, done. The stored timestamp is left unchanged.
- Wrap-around: subtraction is TW-bit modular, so a timer wrap gives the correct elapsed time when the stay is < 2^TW.
- free_count and full are registered and update in the same edge as occupied.
- duration and slot_out change only on done. A rejected op leaves all state untouched apart from err/err_code.
- Reset asserted during EXEC: the operation is discarded, no done/err is produced, and everything returns to reset values.

Test Plan:
- Reset, then check-in with selector 0 at timer=100, three times → done each time, slot_out 1,2,3, occupied=000111, free_count=3.
- Slot 2 occupied since t=100; check-out selector 2 at timer=350 → done, duration=250, occupied=000101.
- Slot 4 checked in at timer=2040; check-out at timer=10 → duration=18 (wrap).
- Fill all 6 slots, then check-in selector 0 → err code 2, full=1, no state change. Check-out of an empty slot → err code 3. Selector 9 → err code 1.
- checkin_req and checkout_req rise on the same edge → err code 1. A second rising edge during the busy cycle → ignored, only one done/err.
- Hold checkin_req high across reset release → no event. Assert rst_n low during EXEC → no done/err, occupied=0.
